// File: rtl/pc_unit_if.sv
// pc_unit_if: bundles the control-stage <-> PC-unit signals.
//   master : control stage; drives the advance request, decode fields and
//            operands, and observes the PC, link value, trap and status.
//   slave  : pc_unit; the mirror image of master.
// Instruction-class codes carried on itype_i:
//   RTYPE=0 ITYPE=1 STYPE=2 BTYPE=3 UTYPE=4 LTYPE=5 HOLD=6
interface pc_unit_if;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ITYPEW = 5;

    // control stage -> pc unit
    logic              pc_readin_i;
    logic [ITYPEW-1:0] itype_i;
    logic              branch_taken_i;
    logic              jump_i;
    logic              jump_reg_i;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   rs1_i;

    // pc unit -> control stage
    logic [XLEN-1:0]   pc_o;
    logic [XLEN-1:0]   pc_plus4_o;
    logic              trap_o;
    logic [XLEN-1:0]   trap_pc_o;
    logic              halted_o;
    logic [XLEN-1:0]   retired_o;

    modport master (
        output pc_readin_i, itype_i, branch_taken_i, jump_i, jump_reg_i,
               imm_i, rs1_i,
        input  pc_o, pc_plus4_o, trap_o, trap_pc_o, halted_o, retired_o
    );

    modport slave (
        input  pc_readin_i, itype_i, branch_taken_i, jump_i, jump_reg_i,
               imm_i, rs1_i,
        output pc_o, pc_plus4_o, trap_o, trap_pc_o, halted_o, retired_o
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with edge-triggered advance, branch/jump target
// selection, misaligned-target trap and HOLD-driven halt.
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous active-high reset
//   bus    - pc_unit_if.slave: advance request, decode fields, operands in;
//            pc, pc+4 link value, trap pulse/address, halted, retired out
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ITYPEW = 5;

    localparam logic [ITYPEW-1:0] BTYPE = ITYPEW'(3);
    localparam logic [ITYPEW-1:0] HOLD  = ITYPEW'(6);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_TRAP = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_req_q;
    logic [XLEN-1:0]   r_pc;
    logic              r_trap;
    logic [XLEN-1:0]   r_trap_pc;
    logic              r_halted;
    logic [XLEN-1:0]   r_retired;

    logic              w_advance;
    logic [XLEN-1:0]   w_target;
    logic              w_misaligned;

    // Rising edge of the request; req_q resets to 1 so a level held
    // through reset release is not seen as a new request.
    assign w_advance = bus.pc_readin_i & ~r_req_q;

    // Next-PC target, fixed priority JALR > JAL > taken branch > sequential.
    always_comb begin
        w_target = r_pc + XLEN'(4);
        if (bus.jump_reg_i) begin
            w_target = (bus.rs1_i + bus.imm_i) & ~XLEN'(1);
        end else if (bus.jump_i) begin
            w_target = r_pc + bus.imm_i;
        end else if ((bus.itype_i == BTYPE) && bus.branch_taken_i) begin
            w_target = r_pc + bus.imm_i;
        end
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);

    // Control FSM and all architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_req_q   <= 1'b1;
            r_pc      <= RESET_PC;
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_req_q <= bus.pc_readin_i;
            unique case (r_state)
                S_RUN: begin
                    r_trap <= 1'b0;
                    if (w_advance) begin
                        // A misaligned target traps whatever the class.
                        if (w_misaligned) begin
                            r_trap_pc <= w_target;
                            r_pc      <= TRAP_VEC;
                            r_trap    <= 1'b1;
                            r_state   <= S_TRAP;
                        end else if (bus.itype_i == HOLD) begin
                            r_retired <= r_retired + XLEN'(1);
                            r_halted  <= 1'b1;
                            r_state   <= S_HALT;
                        end else begin
                            r_pc      <= w_target;
                            r_retired <= r_retired + XLEN'(1);
                        end
                    end
                end
                S_TRAP: begin
                    // Single-cycle trap window; requests here are dropped.
                    r_trap  <= 1'b0;
                    r_state <= S_RUN;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_trap  <= 1'b0;
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_plus4_o = r_pc + XLEN'(4);
    assign bus.trap_o     = r_trap;
    assign bus.trap_pc_o  = r_trap_pc;
    assign bus.halted_o   = r_halted;
    assign bus.retired_o  = r_retired;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a
// behavioural model of the PC advance rules.
module tb_pc_unit;
    localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] P_TRAP_VEC = 32'h0000_0100;
    localparam logic [4:0]  C_RTYPE = 5'd0;
    localparam logic [4:0]  C_BTYPE = 5'd3;
    localparam logic [4:0]  C_HOLD  = 5'd6;

    logic clk;
    logic reset;
    pc_unit_if bus ();

    pc_unit #(.RESET_PC(P_RESET_PC), .TRAP_VEC(P_TRAP_VEC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_trap_pc, m_retired;
    logic        m_trap, m_halted, m_prev_req;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, evaluated from the inputs presented now.
    task automatic model_edge();
        logic        adv;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = P_RESET_PC; m_trap = 1'b0; m_trap_pc = '0;
            m_halted = 1'b0; m_retired = '0; m_prev_req = 1'b1;
            return;
        end
        adv = bus.pc_readin_i && !m_prev_req;
        m_prev_req = bus.pc_readin_i;
        if (m_halted) return;
        if (m_trap) begin
            m_trap = 1'b0;
            return;
        end
        if (!adv) return;
        if (bus.jump_reg_i)                                tgt = (bus.rs1_i + bus.imm_i) & 32'hFFFF_FFFE;
        else if (bus.jump_i)                               tgt = m_pc + bus.imm_i;
        else if (bus.itype_i == C_BTYPE && bus.branch_taken_i) tgt = m_pc + bus.imm_i;
        else                                               tgt = m_pc + 32'd4;
        if (tgt % 4 != 0) begin
            m_trap_pc = tgt; m_pc = P_TRAP_VEC; m_trap = 1'b1;
        end else if (bus.itype_i == C_HOLD) begin
            m_halted = 1'b1; m_retired = m_retired + 1;
        end else begin
            m_pc = tgt; m_retired = m_retired + 1;
        end
    endtask

    task automatic compare_all();
        check("pc",       bus.pc_o,              m_pc);
        check("pc_plus4", bus.pc_plus4_o,        m_pc + 32'd4);
        check("trap",     32'(bus.trap_o),       32'(m_trap));
        check("trap_pc",  bus.trap_pc_o,         m_trap_pc);
        check("halted",   32'(bus.halted_o),     32'(m_halted));
        check("retired",  bus.retired_o,         m_retired);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic rd, input logic [4:0] it, input logic bt,
                          input logic j, input logic jr, input logic [31:0] imm,
                          input logic [31:0] rs1);
        bus.pc_readin_i = rd; bus.itype_i = it; bus.branch_taken_i = bt;
        bus.jump_i = j; bus.jump_reg_i = jr; bus.imm_i = imm; bus.rs1_i = rs1;
    endtask

    // Rising request for one cycle, then low for one cycle.
    task automatic pulse(input logic [4:0] it, input logic bt, input logic j,
                         input logic jr, input logic [31:0] imm, input logic [31:0] rs1);
        set_in(1'b1, it, bt, j, jr, imm, rs1);
        step();
        set_in(1'b0, C_RTYPE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
    endtask

    initial begin
        logic [4:0] it;
        set_in(1'b1, C_RTYPE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        m_pc = 'x; m_trap = 'x; m_trap_pc = 'x; m_halted = 'x; m_retired = 'x; m_prev_req = 1'b1;
        #1;

        // Reset with request high, then hold high: no advance.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        repeat (3) step();
        check("hold_high_pc",      bus.pc_o,      32'h0);
        check("hold_high_retired", bus.retired_o, 32'h0);
        set_in(1'b0, C_RTYPE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();

        // Three sequential advances.
        repeat (3) pulse(C_RTYPE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("seq_pc",      bus.pc_o,       32'h0C);
        check("seq_retired", bus.retired_o,  32'd3);
        check("seq_plus4",   bus.pc_plus4_o, 32'h10);

        // Branch taken / not taken from 0x20.
        pulse(C_RTYPE, 1'b0, 1'b1, 1'b0, 32'h14, 32'd0);
        check("to_20", bus.pc_o, 32'h20);
        pulse(C_BTYPE, 1'b1, 1'b0, 1'b0, -32'sd8, 32'd0);
        check("br_taken", bus.pc_o, 32'h18);
        pulse(C_RTYPE, 1'b0, 1'b1, 1'b0, 32'h8, 32'd0);
        pulse(C_BTYPE, 1'b0, 1'b0, 1'b0, -32'sd8, 32'd0);
        check("br_not_taken", bus.pc_o, 32'h24);

        // JALR beats JAL and clears bit 0.
        pulse(C_RTYPE, 1'b0, 1'b1, 1'b1, 32'd4, 32'h101);
        check("jalr_prio", bus.pc_o, 32'h104);
        check("jalr_retired", bus.retired_o, 32'd8);

        // Misaligned JAL from 0x40 traps for exactly one cycle.
        pulse(C_RTYPE, 1'b0, 1'b1, 1'b0, 32'h40 - 32'h104, 32'd0);
        check("to_40", bus.pc_o, 32'h40);
        set_in(1'b1, C_RTYPE, 1'b0, 1'b1, 1'b0, 32'd2, 32'd0);
        step();
        check("trap_hi",      32'(bus.trap_o), 32'd1);
        check("trap_addr",    bus.trap_pc_o,   32'h42);
        check("trap_vec",     bus.pc_o,        P_TRAP_VEC);
        check("trap_retired", bus.retired_o,   32'd9);
        set_in(1'b0, C_RTYPE, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        check("trap_lo", 32'(bus.trap_o), 32'd0);
        check("trap_pc_held", bus.trap_pc_o, 32'h42);

        // HOLD halts; later pulses do nothing.
        pulse(C_HOLD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("halt_flag",    32'(bus.halted_o), 32'd1);
        check("halt_pc",      bus.pc_o,          P_TRAP_VEC);
        check("halt_retired", bus.retired_o,     32'd10);
        repeat (2) pulse(C_RTYPE, 1'b0, 1'b1, 1'b0, 32'd16, 32'd0);
        check("halt_stays_pc",      bus.pc_o,      P_TRAP_VEC);
        check("halt_stays_retired", bus.retired_o, 32'd10);

        // Reset clears everything even from HALT.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_pc",      bus.pc_o,          P_RESET_PC);
        check("rst_halted",  32'(bus.halted_o), 32'd0);
        check("rst_trap_pc", bus.trap_pc_o,     32'd0);
        check("rst_retired", bus.retired_o,     32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 39) == 0);
            it = 5'($urandom_range(0, 6));
            if (it == C_HOLD && $urandom_range(0, 3) != 0) it = C_RTYPE;
            bus.pc_readin_i    = 1'($urandom_range(0, 1));
            bus.itype_i        = it;
            bus.branch_taken_i = 1'($urandom_range(0, 1));
            bus.jump_i         = ($urandom_range(0, 4) == 0);
            bus.jump_reg_i     = ($urandom_range(0, 5) == 0);
            bus.imm_i          = ($urandom_range(0, 5) == 0) ? 32'($urandom)
                                 : 32'($signed(32'($urandom_range(0, 64))) - 32) << 2;
            bus.rs1_i          = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                 : 32'($urandom_range(0, 1023)) << 2;
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
